mem_arb_ctrl: RTL and testbench

MEM_ARB_CTRL -- requirements
Module: mem_arb_ctrl

---
 rtl/mem_arb_ctrl.sv | 154 +++++++++++++++
 tb/tb_mem_arb_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arb_ctrl.sv
// rtl/mem_arb_ctrl.sv - round-robin multi-channel memory arbiter with valid-tracked storage and bulk clear
module mem_arb_ctrl #(
    parameter  int DATA_W  = 12,
    parameter  int ADDR_W  = 12,
    parameter  int NUM_CH  = 2,
    parameter  int ACC_LAT = 1,
    localparam int GNT_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        req,
    input  logic [NUM_CH-1:0]        we,
    input  logic [NUM_CH-1:0]        ifetch,
    input  logic [NUM_CH*ADDR_W-1:0] addr,
    input  logic [NUM_CH*DATA_W-1:0] wdata,
    input  logic                     clr_mem,
    output logic [NUM_CH-1:0]        done,
    output logic [DATA_W-1:0]        rdata,
    output logic                     rd_invalid,
    output logic                     rd_ifetch,
    output logic [GNT_W-1:0]         gnt_id,
    output logic                     busy
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int LAT_W = (ACC_LAT > 1) ? $clog2(ACC_LAT) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE, CLEAR} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DEPTH-1:0]    valid;
    logic [GNT_W-1:0]    last;
    logic [GNT_W-1:0]    win;
    logic [GNT_W-1:0]    idx;
    logic                any_req;
    logic [LAT_W-1:0]    lat_cnt;
    logic [ADDR_W-1:0]   sweep;
    logic                l_we;
    logic                l_ifetch;
    logic [ADDR_W-1:0]   l_addr;
    logic [DATA_W-1:0]   l_wdata;
    logic                commit;
    logic                start;

    assign busy   = (state != IDLE);
    assign commit = (state == ACCESS) && (lat_cnt == LAT_W'(ACC_LAT - 1));
    assign start  = (state == IDLE) && !clr_mem && any_req;

    // Round-robin pick: scan from farthest to nearest after last grant so the nearest requester wins
    always_comb begin
        win     = last;
        idx     = '0;
        any_req = 1'b0;
        for (int k = NUM_CH; k >= 1; k--) begin
            idx = GNT_W'((int'(last) + k) % NUM_CH);
            if (req[idx]) begin
                win     = idx;
                any_req = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: clear wins over requests in IDLE; ACCESS exits after ACC_LAT cycles
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (clr_mem) begin
                    state_nxt = CLEAR;
                end else if (any_req) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (commit) begin
                    state_nxt = DONE;
                end
            end
            DONE:  state_nxt = IDLE;
            CLEAR: begin
                if (sweep == ADDR_W'(DEPTH - 1)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Grant latching, latency/sweep counters, valid bits and read-result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done       <= '0;
            rdata      <= '0;
            rd_invalid <= 1'b0;
            rd_ifetch  <= 1'b0;
            gnt_id     <= '0;
            last       <= GNT_W'(NUM_CH - 1);
            lat_cnt    <= '0;
            sweep      <= '0;
            valid      <= '0;
            l_we       <= 1'b0;
            l_ifetch   <= 1'b0;
            l_addr     <= '0;
            l_wdata    <= '0;
        end else begin
            done <= '0;
            if (start) begin
                gnt_id   <= win;
                last     <= win;
                l_we     <= we[win];
                l_ifetch <= ifetch[win];
                l_addr   <= addr[int'(win)*ADDR_W +: ADDR_W];
                l_wdata  <= wdata[int'(win)*DATA_W +: DATA_W];
                lat_cnt  <= '0;
            end
            if (state == ACCESS) begin
                if (commit) begin
                    lat_cnt <= '0;
                    done    <= NUM_CH'(1) << gnt_id;
                    if (l_we) begin
                        valid[l_addr] <= 1'b1;
                    end else begin
                        rdata      <= valid[l_addr] ? mem[l_addr] : '0;
                        rd_invalid <= !valid[l_addr];
                        rd_ifetch  <= l_ifetch;
                    end
                end else begin
                    lat_cnt <= lat_cnt + 1'b1;
                end
            end
            if (state == CLEAR) begin
                valid[sweep] <= 1'b0;
                sweep        <= sweep + 1'b1;
            end
        end
    end

    // Data array is never reset; only committed writes touch it
    always_ff @(posedge clk) begin
        if (rst_n && commit && l_we) begin
            mem[l_addr] <= l_wdata;
        end
    end
endmodule

// File: tb/tb_mem_arb_ctrl.sv
// tb/tb_mem_arb_ctrl.sv - self-checking bench for mem_arb_ctrl with transaction-level reference model
module tb_mem_arb_ctrl;
    localparam int NCH  = 2;
    localparam int AW   = 12;
    localparam int DW   = 12;
    localparam int LAT1 = 1;
    localparam int LAT3 = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NCH-1:0]    req = '0, we = '0, ifetch = '0;
    logic [NCH*AW-1:0] addr = '0;
    logic [NCH*DW-1:0] wdata = '0;
    logic              clr_mem = 1'b0;
    logic [NCH-1:0]    done;
    logic [DW-1:0]     rdata;
    logic              rd_invalid, rd_ifetch, busy;
    logic [0:0]        gnt_id;

    logic [NCH-1:0]    req3 = '0, we3 = '0, ifetch3 = '0;
    logic [NCH*AW-1:0] addr3 = '0;
    logic [NCH*DW-1:0] wdata3 = '0;
    logic              clr3 = 1'b0;
    logic [NCH-1:0]    done3;
    logic [DW-1:0]     rdata3;
    logic              rd_inv3, rd_if3, busy3;
    logic [0:0]        gnt3;

    mem_arb_ctrl #(.DATA_W(DW), .ADDR_W(AW), .NUM_CH(NCH), .ACC_LAT(LAT1)) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .ifetch(ifetch), .addr(addr),
        .wdata(wdata), .clr_mem(clr_mem), .done(done), .rdata(rdata),
        .rd_invalid(rd_invalid), .rd_ifetch(rd_ifetch), .gnt_id(gnt_id), .busy(busy)
    );

    mem_arb_ctrl #(.DATA_W(DW), .ADDR_W(AW), .NUM_CH(NCH), .ACC_LAT(LAT3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .req(req3), .we(we3), .ifetch(ifetch3), .addr(addr3),
        .wdata(wdata3), .clr_mem(clr3), .done(done3), .rdata(rdata3),
        .rd_invalid(rd_inv3), .rd_ifetch(rd_if3), .gnt_id(gnt3), .busy(busy3)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // reference model: memory contents, valid map, round-robin pointer, held read results
    logic [DW-1:0] mmem [4096];
    bit            mvalid [4096];
    int            mlast;
    logic [DW-1:0] e_rdata;
    logic          e_inv, e_if;
    bit            p_req [NCH];
    logic          p_we [NCH], p_if [NCH];
    logic [AW-1:0] p_addr [NCH];
    logic [DW-1:0] p_wdata [NCH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4096; i++) mvalid[i] = 1'b0;
        for (int c = 0; c < NCH; c++) p_req[c] = 1'b0;
        mlast   = NCH - 1;
        e_rdata = '0;
        e_inv   = 1'b0;
        e_if    = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = '0;
        clr_mem = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic chk_reset_state();
        chk("rst_done", done, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_rd_invalid", rd_invalid, 0);
        chk("rst_rd_ifetch", rd_ifetch, 0);
        chk("rst_gnt_id", gnt_id, 0);
        chk("rst_busy", busy, 0);
    endtask

    task automatic post(input int ch, input logic w, input logic f, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[ch] = 1'b1;
        we[ch] = w;
        ifetch[ch] = f;
        addr[ch*AW +: AW] = a;
        wdata[ch*DW +: DW] = d;
        p_req[ch] = 1'b1;
        p_we[ch] = w;
        p_if[ch] = f;
        p_addr[ch] = a;
        p_wdata[ch] = d;
    endtask

    // Called at an IDLE-cycle negedge; runs one transaction to completion against the model
    task automatic serve(input bit rnd, output int g);
        int w, n, i, o;
        bit seen;
        logic lw, lf;
        logic [AW-1:0] la;
        logic [DW-1:0] ld;
        w = -1;
        g = -1;
        for (int k = 1; k <= NCH; k++) begin
            i = (mlast + k) % NCH;
            if (p_req[i] && w < 0) w = i;
        end
        if (w < 0) return;
        chk("idle_busy", busy, 0);
        lw = p_we[w]; lf = p_if[w]; la = p_addr[w]; ld = p_wdata[w];
        @(posedge clk);
        #1;
        addr[w*AW +: AW] = AW'($urandom);
        wdata[w*DW +: DW] = DW'($urandom);
        we[w] = 1'($urandom);
        ifetch[w] = 1'($urandom);
        o = (w + 1) % NCH;
        if (rnd && !p_req[o] && $urandom_range(0, 1) == 1)
            post(o, 1'($urandom), 1'($urandom), AW'($urandom_range(0, 15)), DW'($urandom));
        n = 0;
        seen = 0;
        while (!seen && n < 12) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                chk("gnt_id", gnt_id, w);
                chk("busy_access", busy, 1);
            end
            if (done != 0) seen = 1;
        end
        chk("done_latency", n, LAT1 + 1);
        chk("done_onehot", done, 1 << w);
        if (lw) begin
            mmem[la] = ld;
            mvalid[la] = 1'b1;
        end else begin
            e_rdata = mvalid[la] ? mmem[la] : '0;
            e_inv = !mvalid[la];
            e_if = lf;
        end
        chk("rdata", rdata, e_rdata);
        chk("rd_invalid", rd_invalid, e_inv);
        chk("rd_ifetch", rd_ifetch, e_if);
        g = int'(gnt_id);
        mlast = w;
        p_req[w] = 1'b0;
        req[w] = 1'b0;
        @(negedge clk);
        chk("done_single", done, 0);
    endtask

    initial begin
        int g, n;
        do_reset();
        chk_reset_state();

        // alternating round-robin with both channels requesting
        post(0, 1'b1, 1'b0, 12'o0010, 12'o1111);
        post(1, 1'b1, 1'b0, 12'o0011, 12'o2222);
        serve(1'b0, g); chk("rr_order0", g, 0);
        post(0, 1'b1, 1'b0, 12'o0012, 12'o3333);
        serve(1'b0, g); chk("rr_order1", g, 1);
        post(1, 1'b0, 1'b0, 12'o0010, 12'o0000);
        serve(1'b0, g); chk("rr_order2", g, 0);
        serve(1'b0, g); chk("rr_order3", g, 1);
        chk("rr_read_back", rdata, 12'o1111);

        // read of never-written location after reset
        do_reset();
        post(1, 1'b0, 1'b0, 12'o0017, 12'o0000);
        serve(1'b0, g);
        chk("inv_rdata", rdata, 0);
        chk("inv_flag", rd_invalid, 1);

        // write then read back
        post(0, 1'b1, 1'b0, 12'o0200, 12'o7402);
        serve(1'b0, g);
        post(0, 1'b0, 1'b0, 12'o0200, 12'o0000);
        serve(1'b0, g);
        chk("wr_rd_data", rdata, 12'o7402);
        chk("wr_rd_valid", rd_invalid, 0);

        // ifetch tag, then a write must not disturb read results
        post(1, 1'b0, 1'b1, 12'o0200, 12'o0000);
        serve(1'b0, g);
        chk("ifetch_tag", rd_ifetch, 1);
        post(0, 1'b1, 1'b0, 12'o0201, 12'o3333);
        serve(1'b0, g);
        chk("hold_rdata", rdata, 12'o7402);
        chk("hold_ifetch", rd_ifetch, 1);
        chk("hold_invalid", rd_invalid, 0);

        do_reset();
        chk_reset_state();

        // reset in the middle of a write access
        post(0, 1'b1, 1'b0, 12'o0050, 12'o1234);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        req = '0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            chk("abort_no_done", done, 0);
            @(negedge clk);
        end
        chk("abort_busy", busy, 0);
        post(0, 1'b0, 1'b0, 12'o0050, 12'o0000);
        serve(1'b0, g);
        chk("abort_invalid", rd_invalid, 1);

        // randomized traffic against the model
        for (int it = 0; it < 40; it++) begin
            for (int c = 0; c < NCH; c++)
                if (!p_req[c] && $urandom_range(0, 1) == 1)
                    post(c, 1'($urandom), 1'($urandom), AW'($urandom_range(0, 15)), DW'($urandom));
            if (!p_req[0] && !p_req[1])
                post(int'($urandom_range(0, 1)), 1'($urandom), 1'($urandom), AW'($urandom_range(0, 15)), DW'($urandom));
            serve(1'b1, g);
        end

        // ACC_LAT=3 instance: write, then clear with a read request pending
        @(negedge clk);
        req3[0] = 1'b1; we3[0] = 1'b1; addr3[AW-1:0] = 12'o0100; wdata3[DW-1:0] = 12'o5555;
        @(posedge clk);
        n = 0;
        do begin @(negedge clk); n++; end while (done3 == 0 && n < 12);
        chk("l3_wr_latency", n, LAT3 + 1);
        req3[0] = 1'b0;
        @(negedge clk);
        we3[0] = 1'b0;
        clr3 = 1'b1;
        req3[0] = 1'b1;
        @(posedge clk);
        n = 0;
        @(negedge clk);
        while (busy3 === 1'b1 && n < 5000) begin
            n++;
            @(negedge clk);
        end
        chk("clear_cycles", n, 4096);
        clr3 = 1'b0;
        @(posedge clk);
        n = 0;
        do begin @(negedge clk); n++; end while (done3 == 0 && n < 12);
        chk("l3_rd_latency", n, LAT3 + 1);
        chk("l3_done", done3, 2'b01);
        chk("l3_rdata", rdata3, 0);
        chk("l3_invalid", rd_inv3, 1);
        req3[0] = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
